// File: rtl/hud_score_overlay_pkg.sv
// rtl/hud_score_overlay_pkg.sv - shared HUD definitions: segment codes, BCD width, default geometry
package hud_score_overlay_pkg;

    localparam int BCD_W = 4;

    localparam int DEF_X0      = 16;
    localparam int DEF_Y0      = 16;
    localparam int DEF_DIG_W   = 12;
    localparam int DEF_DIG_H   = 20;
    localparam int DEF_DIG_GAP = 4;
    localparam int DEF_SEG_T   = 2;
    localparam logic [23:0] DEF_SCORE_BGR = 24'hFFFFFF;

    // Segment codes in {g,f,e,d,c,b,a} order
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    function automatic logic [6:0] seg_code(input logic [BCD_W-1:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_pixel.sv
// rtl/seven_seg_pixel.sv - decides whether a cell-local pixel falls on a lit segment of one digit
module seven_seg_pixel
    import hud_score_overlay_pkg::*;
#(
    parameter int DIG_W = DEF_DIG_W,
    parameter int DIG_H = DEF_DIG_H,
    parameter int SEG_T = DEF_SEG_T
) (
    input  logic [BCD_W-1:0] digit,
    input  logic [3:0]       cx,
    input  logic [4:0]       ry,
    output logic             on
);

    localparam int MID = DIG_H / 2;

    logic [6:0] segs;
    logic [6:0] lit;
    logic       hz;
    int         col;
    int         row;

    always_comb begin
        col  = int'(cx);
        row  = int'(ry);
        segs = seg_code(digit);
        hz   = (col >= SEG_T) && (col < DIG_W - SEG_T);
        lit  = '0;
        lit[0] = hz && (row < SEG_T);
        lit[1] = (col >= DIG_W - SEG_T) && (col < DIG_W) && (row >= SEG_T) && (row < MID);
        lit[2] = (col >= DIG_W - SEG_T) && (col < DIG_W) && (row >= MID) && (row < DIG_H - SEG_T);
        lit[3] = hz && (row >= DIG_H - SEG_T) && (row < DIG_H);
        lit[4] = (col < SEG_T) && (row >= MID) && (row < DIG_H - SEG_T);
        lit[5] = (col < SEG_T) && (row >= SEG_T) && (row < MID);
        // middle bar straddles the cell centre line
        lit[6] = hz && (row >= MID - 1) && (row < MID - 1 + SEG_T);
        on     = |(lit & segs);
    end

endmodule

// File: rtl/hud_score_overlay.sv
// rtl/hud_score_overlay.sv - BCD distance score, high score and zero-latency seven-segment overlay
module hud_score_overlay
    import hud_score_overlay_pkg::*;
#(
    parameter int          X0        = DEF_X0,
    parameter int          Y0        = DEF_Y0,
    parameter int          DIG_W     = DEF_DIG_W,
    parameter int          DIG_H     = DEF_DIG_H,
    parameter int          DIG_GAP   = DEF_DIG_GAP,
    parameter int          SEG_T     = DEF_SEG_T,
    parameter logic [23:0] SCORE_BGR = DEF_SCORE_BGR
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        internal_reset,
    input  logic        clk_div,
    input  logic        run,
    input  logic        end_game,
    input  logic [2:0]  speed,
    input  logic        blank_n,
    input  logic        vs,
    input  logic [23:0] bgr_in,
    output logic [23:0] bgr_out,
    output logic [15:0] score_bcd,
    output logic [15:0] hiscore_bcd
);

    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank_q;
    logic        vs_q;
    logic        clk_div_q;
    logic        end_q;
    logic [15:0] score;
    logic [15:0] score_disp;
    logic [15:0] hiscore;
    logic        tick;
    logic        end_rise;

    // Decimal add of a small increment across all four digits, pinned at 9999
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] v, input logic [2:0] inc);
        logic [15:0] r;
        logic [4:0]  s;
        logic [4:0]  carry;
        r     = '0;
        carry = {2'b00, inc};
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, v[i*BCD_W +: BCD_W]} + carry;
            if (s > 5'd9) begin
                r[i*BCD_W +: BCD_W] = 4'(s - 5'd10);
                carry = 5'd1;
            end else begin
                r[i*BCD_W +: BCD_W] = s[3:0];
                carry = 5'd0;
            end
        end
        return (carry != 5'd0) ? 16'h9999 : r;
    endfunction

    assign tick     = clk_div & ~clk_div_q;
    assign end_rise = end_game & ~end_q;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x       <= '0;
            y       <= '0;
            blank_q <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            blank_q <= blank_n;
            vs_q    <= vs;
            if (!vs) begin
                x <= '0;
                y <= '0;
            end else if (blank_q && !blank_n) begin
                x <= '0;
                if (y != 10'h3FF) y <= y + 10'd1;
            end else if (blank_n && x != 10'h3FF) begin
                x <= x + 10'd1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_div_q  <= 1'b0;
            end_q      <= 1'b0;
            score      <= '0;
            score_disp <= '0;
            hiscore    <= '0;
        end else begin
            clk_div_q <= clk_div;
            end_q     <= end_game;
            if (internal_reset) begin
                score <= '0;
            end else if (tick && run) begin
                score <= bcd_add_sat(score, speed);
            end
            if (vs_q && !vs) score_disp <= score;
            // valid BCD orders the same as binary, MSD first
            if (end_rise && score > hiscore) hiscore <= score;
        end
    end

    assign score_bcd   = score;
    assign hiscore_bcd = hiscore;

    logic [9:0] dy;
    logic       y_in;
    logic [3:0] on_k;

    assign dy   = y - 10'(Y0);
    assign y_in = (y >= 10'(Y0)) && (dy < 10'(DIG_H));

    for (genvar k = 0; k < 4; k++) begin : g_digit
        localparam int BASE = X0 + k * (DIG_W + DIG_GAP);
        logic [9:0] dx;
        logic       in_cell;
        logic       seg_on;

        assign dx      = x - 10'(BASE);
        assign in_cell = (x >= 10'(BASE)) && (dx < 10'(DIG_W)) && y_in;

        seven_seg_pixel #(
            .DIG_W (DIG_W),
            .DIG_H (DIG_H),
            .SEG_T (SEG_T)
        ) u_seg (
            .digit (score_disp[(3-k)*BCD_W +: BCD_W]),
            .cx    (dx[3:0]),
            .ry    (dy[4:0]),
            .on    (seg_on)
        );

        assign on_k[k] = in_cell & seg_on;
    end

    assign bgr_out = (blank_n && |on_k) ? SCORE_BGR : bgr_in;

endmodule
